// File: rtl/score_uart_tx.sv
// Scoreboard snapshot transmitter: latches score_a/score_b/shot_clock on a send request
// and emits "Annn Bnnn Tnn\r\n" as 8N1 UART bytes, LSB first.
module score_uart_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] score_a,
  input  logic [7:0] score_b,
  input  logic [5:0] shot_clock,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("score_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    ra_q, ra_d, rb_q, rb_d, rt_q, rt_d;
  logic [3:0]    ha_q, ha_d, ta_q, ta_d, hb_q, hb_d, tb_q, tb_d, tt_q, tt_d;
  logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic          conv_done_s, baud_end_s;
  logic [7:0]    frame_byte_s;

  // One repeated-subtraction step: {remainder, hundreds, tens}; units are what remains.
  function automatic logic [15:0] dec_step(input logic [7:0] rem, input logic [3:0] hund,
                                           input logic [3:0] tens);
    if (rem >= 8'd100) begin
      dec_step = {rem - 8'd100, hund + 4'd1, tens};
    end else if (rem >= 8'd10) begin
      dec_step = {rem - 8'd10, hund, tens + 4'd1};
    end else begin
      dec_step = {rem, hund, tens};
    end
  endfunction

  assign conv_done_s = (ra_q < 8'd10) && (rb_q < 8'd10) && (rt_q < 8'd10);
  assign baud_end_s  = (baud_q == BAUD_LAST);

  // Frame text: byte index to ASCII character.
  always_comb begin
    frame_byte_s = 8'h20;
    case (idx_q)
      4'd0:    frame_byte_s = 8'h41;
      4'd1:    frame_byte_s = 8'h30 | {4'h0, ha_q};
      4'd2:    frame_byte_s = 8'h30 | {4'h0, ta_q};
      4'd3:    frame_byte_s = 8'h30 | {4'h0, ra_q[3:0]};
      4'd5:    frame_byte_s = 8'h42;
      4'd6:    frame_byte_s = 8'h30 | {4'h0, hb_q};
      4'd7:    frame_byte_s = 8'h30 | {4'h0, tb_q};
      4'd8:    frame_byte_s = 8'h30 | {4'h0, rb_q[3:0]};
      4'd10:   frame_byte_s = 8'h54;
      4'd11:   frame_byte_s = 8'h30 | {4'h0, tt_q};
      4'd12:   frame_byte_s = 8'h30 | {4'h0, rt_q[3:0]};
      4'd13:   frame_byte_s = 8'h0D;
      4'd14:   frame_byte_s = 8'h0A;
      default: frame_byte_s = 8'h20;
    endcase
  end

  // Next-state and datapath for the frame sequencer.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ra_d = ra_q;  rb_d = rb_q;  rt_d = rt_q;
    ha_d = ha_q;  ta_d = ta_q;  hb_d = hb_q;  tb_d = tb_q;  tt_d = tt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (send) begin
          ra_d = score_a;
          rb_d = score_b;
          rt_d = {2'b00, shot_clock};
          ha_d = 4'd0;  ta_d = 4'd0;  hb_d = 4'd0;  tb_d = 4'd0;  tt_d = 4'd0;
          idx_d   = 4'd0;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        {ra_d, ha_d, ta_d} = dec_step(ra_q, ha_q, ta_q);
        {rb_d, hb_d, tb_d} = dec_step(rb_q, hb_q, tb_q);
        // shot_clock never reaches 100, so only the tens step applies
        if (rt_q >= 8'd10) begin
          rt_d = rt_q - 8'd10;
          tt_d = tt_q + 4'd1;
        end else begin
          rt_d = rt_q;
          tt_d = tt_q;
        end
        if (conv_done_s) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_CONV;
        end
      end
      S_LOAD: begin
        shift_d = frame_byte_s;
        baud_d  = {CW{1'b0}};
        state_d = S_START;
      end
      S_START: begin
        if (baud_end_s) begin
          baud_d  = {CW{1'b0}};
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_d = {CW{1'b0}};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_d = {CW{1'b0}};
          if (idx_q == 4'd14) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end else begin
          baud_d = baud_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered, so tx/busy/done change on the same edge
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= {CW{1'b0}};
      bit_q   <= 3'd0;
      idx_q   <= 4'd0;
      shift_q <= 8'h00;
      ra_q <= 8'd0;  rb_q <= 8'd0;  rt_q <= 8'd0;
      ha_q <= 4'd0;  ta_q <= 4'd0;  hb_q <= 4'd0;  tb_q <= 4'd0;  tt_q <= 4'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ra_q <= ra_d;  rb_q <= rb_d;  rt_q <= rt_d;
      ha_q <= ha_d;  ta_q <= ta_d;  hb_q <= hb_d;  tb_q <= tb_d;  tt_q <= tt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_score_uart_tx.sv
// Directed bench for score_uart_tx at DIV=10: decodes tx with a mid-bit sampler and
// compares whole frames, timing and handshake against hand-written expectations.
module tb_score_uart_tx;

  logic       clk = 1'b0;
  logic       rst, send, tx, busy, done;
  logic [7:0] score_a, score_b;
  logic [5:0] shot_clock;
  int         errs = 0;
  int         checks = 0;
  int         done_cnt = 0;

  score_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk(clk), .rst(rst), .send(send), .score_a(score_a), .score_b(score_b),
    .shot_clock(shot_clock), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // counts every cycle done is high, so a stretched pulse shows up as extra counts
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_pulse();
    send = 1'b1;
    fork
      begin @(negedge clk); send = 1'b0; end
    join_none
  endtask

  task automatic rx_byte(input int limit, output logic [7:0] b, output logic found,
                         inout int ferr);
    int n;
    n = 0;
    b = 8'h00;
    do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < limit);
    found = (tx === 1'b0);
    if (!found) ferr++;
    repeat (5) @(negedge clk);
    if (tx !== 1'b0 || busy !== 1'b1) ferr++;
    for (int k = 0; k < 8; k++) begin
      repeat (10) @(negedge clk);
      b[k] = tx;
      if (busy !== 1'b1) ferr++;
    end
    repeat (10) @(negedge clk);
    if (tx !== 1'b1 || busy !== 1'b1) ferr++;
  endtask

  task automatic rx_frame(input string tag, input logic [119:0] exp, input int first_limit);
    logic [119:0] got;
    logic [7:0]   b;
    logic         found, first_found;
    int           ferr;
    got = '0;
    ferr = 0;
    first_found = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rx_byte((i == 0) ? first_limit : 7, b, found, ferr);
      if (i == 0) first_found = found;
      got = {got[111:0], b};
    end
    chk({tag, "_lat"}, first_found, 1'b1);
    chk({tag, "_framing"}, ferr, 0);
    chk({tag, "_text"}, got, exp);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (tx === lvl && n < 200) begin n++; @(negedge clk); end
  endtask

  // 'A' = 0x41: start(0) x10, bit0(1) x10, bits1..5(0) x50
  task automatic measure_widths();
    int n, w0, w1, w2;
    n = 0;
    while (tx !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    run_len(1'b0, w0);
    run_len(1'b1, w1);
    run_len(1'b0, w2);
    chk("start_width", w0, 10);
    chk("bit0_width", w1, 10);
    chk("bits1_5_width", w2, 50);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk({tag, "_quiet"}, bad, 0);
  endtask

  initial begin
    int d0, n, ferr;
    logic [7:0] b;
    logic found;
    rst = 1'b1; send = 1'b0; score_a = 8'd0; score_b = 8'd0; shot_clock = 6'd0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;

    quiet("idle", 5000);

    // basic frame plus bit-width measurement on the first byte
    d0 = done_cnt;
    score_a = 8'd0; score_b = 8'd0; shot_clock = 6'd24;
    send_pulse();
    fork
      rx_frame("basic", "A000 B000 T24\r\n", 33);
      measure_widths();
    join
    wait_done("basic");
    @(negedge clk);
    chk("basic_done_cnt", done_cnt - d0, 1);

    // extremes
    d0 = done_cnt;
    score_a = 8'd255; score_b = 8'd7; shot_clock = 6'd0;
    send_pulse();
    rx_frame("ext1", "A255 B007 T00\r\n", 33);
    wait_done("ext1");
    @(negedge clk);
    score_a = 8'd100; score_b = 8'd99; shot_clock = 6'd63;
    send_pulse();
    rx_frame("ext2", "A100 B099 T63\r\n", 33);
    wait_done("ext2");
    @(negedge clk);
    chk("ext_done_cnt", done_cnt - d0, 2);

    // snapshot held while inputs change; sends during busy are dropped
    d0 = done_cnt;
    score_a = 8'd12; score_b = 8'd34; shot_clock = 6'd5;
    send_pulse();
    fork
      rx_frame("snap", "A012 B034 T05\r\n", 33);
      begin
        repeat (50) @(negedge clk);
        score_a = 8'd45;
        repeat (3) begin
          send = 1'b1;
          @(negedge clk);
          send = 1'b0;
          repeat (20) @(negedge clk);
        end
      end
    join
    wait_done("snap");
    quiet("snap_after", 300);
    chk("snap_done_cnt", done_cnt - d0, 1);

    // send held across two frames; second frame picks up the new score_b
    d0 = done_cnt;
    score_a = 8'd1; score_b = 8'd3; shot_clock = 6'd2;
    send = 1'b1;
    fork
      begin
        rx_frame("held1", "A001 B003 T02\r\n", 33);
        wait_done("held1");
        rx_frame("held2", "A001 B005 T02\r\n", 33);
        wait_done("held2");
      end
      begin
        repeat (100) @(negedge clk);
        score_b = 8'd5;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        send = 1'b0;
      end
    join
    @(negedge clk);
    chk("held_done_cnt", done_cnt - d0, 2);
    quiet("held_after", 100);

    // reset during the data bits of byte 6
    d0 = done_cnt;
    ferr = 0;
    score_a = 8'd50; score_b = 8'd60; shot_clock = 6'd7;
    send_pulse();
    for (int i = 0; i < 6; i++) rx_byte((i == 0) ? 33 : 7, b, found, ferr);
    chk("rstmid_prefix", ferr, 0);
    n = 0;
    while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_tx", tx, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    quiet("rstmid", 30);
    chk("rstmid_done_cnt", done_cnt - d0, 0);
    score_a = 8'd9; score_b = 8'd8; shot_clock = 6'd7;
    send_pulse();
    rx_frame("rstmid_next", "A009 B008 T07\r\n", 33);
    wait_done("rstmid_next");
    @(negedge clk);
    chk("rstmid_next_done_cnt", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/score_uart_tx.md
Name: score_uart_tx

Overview:
- Serial transmitter that sends a snapshot of the scoreboard state (score_a, score_b, shot_clock) as one ASCII text frame over a UART TX line (8N1, LSB first).
- Runs at the 100 MHz board clock next to scoreboard_logic, so the score can be mirrored on a remote terminal or display.
- Converts binary values to decimal digits internally.
- Sends one frame per accepted send request.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- Derived: DIV = CLK_FREQ/BAUD, integer truncation; 868 at defaults. Elaboration must fail if DIV < 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- send  input  1  request one frame. Sampled every cycle; level or pulse both allowed.
- score_a  input  8  team A score, binary 0..255.
- score_b  input  8  team B score, binary 0..255.
- shot_clock  input  6  shot clock, binary 0..63.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high from send acceptance through the end of the last stop bit.
- done  output  1  one-cycle pulse after the final stop bit completes.

Behaviour:
- Reset (any state, including mid-frame): on the next edge tx=1, busy=0, done=0, FSM=IDLE, baud counter=0, byte index=0. The partial frame is abandoned; no glitch low on tx.
- Frame: 15 bytes, in this order:
  - 'A' d2 d1 d0 ' ' for score_a, as 3 decimal digits with leading zeros
  - 'B' d2 d1 d0 ' ' for score_b, same format
  - 'T' t1 t0 for shot_clock, as 2 decimal digits
  - CR (0x0D) LF (0x0A)
  - Digits are ASCII 0x30+value.
- Accept: in IDLE with send=1, latch all three inputs into snapshot registers and set busy=1 on the same edge. Later input changes do not affect the frame in flight.
- send while busy=1 is ignored and not queued.
- FSM states:
  - IDLE: wait for accept, then go to CONV.
  - CONV: sequential binary-to-decimal by repeated subtraction, 100s then 10s, remainder gives the units. At most one subtraction per cycle per value; values may run in parallel. Then go to LOAD.
  - LOAD: select byte[index], then go to START.
  - START: tx=0 for DIV cycles.
  - DATA: 8 bits LSB first, each DIV cycles.
  - STOP: tx=1 for DIV cycles. Then index+1 and back to LOAD if index<14; else go to IDLE and pulse done.
- Latency: the first start bit begins at most 32 cycles after the accept edge.
- Between bytes, the gap LOAD→START is at most 2 cycles, with tx held high.
- Bit timing: every bit lasts exactly DIV clk cycles. The baud counter restarts at each start bit.
- done and busy: busy falls on the same edge done rises. done is high for exactly 1 cycle.
- Back-to-back frames: with send held high, a new accept occurs on the first IDLE cycle after done. The new frame uses fresh input values.
- Boundaries:
  - score 0 → "000"; score 255 → "255"; shot_clock 0 → "00"; 63 → "63".
  - Out-of-range never arises from the port widths except shot_clock 64+, which cannot occur at 6 bits.

Test Plan:
- All tests use CLK_FREQ=1000 and BAUD=100, so DIV=10.
- Basic frame: reset, then score_a=0, score_b=0, shot_clock=24, one-cycle send.
  → tx decodes to "A000 B000 T24\r\n" (15 bytes).
  → each bit is 10 cycles; the start bit is within 32 cycles of send.
  → done pulses once; busy spans the whole frame.
- Extremes: score_a=255, score_b=7, shot_clock=0.
  → "A255 B007 T00\r\n". score_a=100, score_b=99, shot_clock=63 → "A100 B099 T63\r\n".
- Snapshot and ignore: accept with score_a=12. While busy, change score_a to 45 and pulse send 3 times.
  → exactly one frame, containing "A012". No second frame; done pulses once.
- Held send: send held high for 2 frames' duration while score_b changes 3→5 during frame 1.
  → frame 1 shows B003, frame 2 shows B005.
  → the frame 2 start bit begins within 33 cycles of the frame 1 done.
- Reset mid-frame: assert rst for 1 cycle during the DATA bits of byte 6.
  → next cycle tx=1, busy=0, no done. A subsequent send produces a complete, correct frame from byte 'A'.
- Idle line: no send for 5000 cycles after reset.
  → tx stays 1, busy 0, done 0 throughout.
